// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- next-PC generator and PC register for the fetch stage.
//
// Picks the next fetch address from sequential increment, PC-relative
// branch, register jump, SIIC trap, RTI return, halt and fetch stall.
// Redirects come from EX; stall comes from the hazard unit. A misaligned
// jump/branch target is turned into a trap to EXC_VEC with a one-cycle
// misalign pulse.
//
// Optional feature macro: PC_EPC_EN
//   defined   : traps save the return address in epc and enter EXC; rti in
//               EXC returns to epc; a trap while in EXC is a double fault
//               that halts the core.
//   undefined : no EXC state, every trap vectors to EXC_VEC, rti ignored,
//               epc tied to zero.
//
// Parameters
//   WIDTH      address width
//   INC        sequential increment in bytes (power of 2, >= 1)
//   RESET_VEC  PC value on reset
//   EXC_VEC    trap handler address
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   stall     in   hold PC (only affects sequential advance)
//   br_taken  in   PC-relative branch taken in EX
//   jr        in   register jump in EX
//   redir_pc  in   PC of the EX instruction
//   imm       in   sign-extended displacement
//   rs        in   jump base register
//   siic      in   illegal-instruction trap from EX
//   rti       in   return from trap
//   halt      in   HALT reached EX
//   pc        out  current fetch address (registered)
//   pc_inc    out  pc + INC
//   next_pc   out  value loaded on the next edge
//   halted    out  high in the HALTED state
//   misalign  out  one-cycle pulse after a misaligned redirect
//   epc       out  saved return address
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int               WIDTH     = 16,
    parameter int               INC       = 2,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic             jr,
    input  logic [WIDTH-1:0] redir_pc,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] rs,
    input  logic             siic,
    input  logic             rti,
    input  logic             halt,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_inc,
    output logic [WIDTH-1:0] next_pc,
    output logic             halted,
    output logic             misalign,
    output logic [WIDTH-1:0] epc
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EXC    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
    // For INC == 1 the mask is zero, so nothing is ever misaligned.
    localparam logic [WIDTH-1:0] INC_MASK = INC_W - WIDTH'(1);

    function automatic logic is_misaligned(input logic [WIDTH-1:0] addr);
        return (addr & INC_MASK) != '0;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q;
    logic             misalign_q, misalign_d;
    logic [WIDTH-1:0] br_tgt, jr_tgt, ret_addr;
    logic             trap_req;

    // All additions wrap modulo 2^WIDTH by truncation.
    assign pc_inc   = pc_q + INC_W;
    assign br_tgt   = redir_pc + INC_W + imm;
    assign jr_tgt   = rs + imm;
    assign ret_addr = redir_pc + INC_W;

`ifdef PC_EPC_EN
    logic [WIDTH-1:0] epc_q, epc_d;
`else
    // rti and the return address have no effect without the EPC feature.
    logic unused_no_epc;
    assign unused_no_epc = rti ^ (^ret_addr);
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        next_pc    = pc_inc;
        state_d    = state_q;
        misalign_d = 1'b0;
        trap_req   = 1'b0;
`ifdef PC_EPC_EN
        epc_d      = epc_q;
`endif

        if (state_q == ST_HALTED) begin
            next_pc = pc_q;
        end else begin
            if (siic) begin
                trap_req = 1'b1;
`ifdef PC_EPC_EN
            end else if (rti && state_q == ST_EXC) begin
                next_pc = epc_q;
                state_d = ST_RUN;
`endif
            end else if (halt) begin
                next_pc = pc_q;
                state_d = ST_HALTED;
            end else if (jr) begin
                // jr outranks br_taken if both are (illegally) asserted.
                if (is_misaligned(jr_tgt)) begin
                    trap_req   = 1'b1;
                    misalign_d = 1'b1;
                end else begin
                    next_pc = jr_tgt;
                end
            end else if (br_taken) begin
                if (is_misaligned(br_tgt)) begin
                    trap_req   = 1'b1;
                    misalign_d = 1'b1;
                end else begin
                    next_pc = br_tgt;
                end
            end else if (stall) begin
                next_pc = pc_q;
            end

            if (trap_req) begin
`ifdef PC_EPC_EN
                if (state_q == ST_EXC) begin
                    // Trap inside the handler: double fault, stop here.
                    next_pc = pc_q;
                    state_d = ST_HALTED;
                end else begin
                    next_pc = EXC_VEC;
                    epc_d   = ret_addr;
                    state_d = ST_EXC;
                end
`else
                next_pc = EXC_VEC;
`endif
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VEC;
            state_q    <= ST_RUN;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= next_pc;
            state_q    <= state_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef PC_EPC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) epc_q <= '0;
        else     epc_q <= epc_d;
    end
    assign epc = epc_q;
`else
    assign epc = '0;
`endif

    assign pc       = pc_q;
    assign halted   = (state_q == ST_HALTED);
    assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen (WIDTH=16, INC=2, RESET_VEC=0,
// EXC_VEC=2). Directed scenarios plus randomized stimulus, every cycle
// compared against a behavioural model of the next-PC rules.
// Honours PC_EPC_EN the same way as the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_gen;

    localparam int W    = 16;
    localparam int INC  = 2;
    localparam int MOD  = 65536;
    localparam int RVEC = 0;
    localparam int EVEC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0, br_taken = 1'b0, jr = 1'b0;
    logic [W-1:0]  redir_pc = '0, imm = '0, rs = '0;
    logic          siic = 1'b0, rti = 1'b0, halt = 1'b0;
    logic [W-1:0]  pc, pc_inc, next_pc, epc;
    logic          halted, misalign;

    pc_gen #(.WIDTH(W), .INC(INC), .RESET_VEC(16'h0000), .EXC_VEC(16'h0002)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .jr(jr),
        .redir_pc(redir_pc), .imm(imm), .rs(rs), .siic(siic), .rti(rti),
        .halt(halt), .pc(pc), .pc_inc(pc_inc), .next_pc(next_pc),
        .halted(halted), .misalign(misalign), .epc(epc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_pc, m_epc;
    bit m_halted, m_exc, m_mis;
    // predicted post-edge values
    int p_pc, p_epc;
    bit p_halted, p_exc, p_mis;

    task automatic model_reset();
        m_pc = RVEC; m_epc = 0; m_halted = 0; m_exc = 0; m_mis = 0;
    endtask

    task automatic predict();
        int  tgt;
        bit  trap;
        trap     = 0;
        p_pc     = (m_pc + INC) % MOD;
        p_epc    = m_epc;
        p_halted = m_halted;
        p_exc    = m_exc;
        p_mis    = 0;
        if (m_halted) begin
            p_pc = m_pc;
            return;
        end
        if (siic) trap = 1;
`ifdef PC_EPC_EN
        else if (rti && m_exc) begin p_pc = m_epc; p_exc = 0; end
`endif
        else if (halt) begin p_pc = m_pc; p_halted = 1; end
        else if (jr || br_taken) begin
            if (jr) tgt = (int'(rs) + int'(imm)) % MOD;
            else    tgt = (int'(redir_pc) + INC + int'(imm)) % MOD;
            if (tgt % INC != 0) begin trap = 1; p_mis = 1; end
            else p_pc = tgt;
        end
        else if (stall) p_pc = m_pc;
        if (trap) begin
`ifdef PC_EPC_EN
            if (m_exc) begin p_pc = m_pc; p_halted = 1; p_exc = 0; end
            else begin
                p_pc  = EVEC;
                p_epc = (int'(redir_pc) + INC) % MOD;
                p_exc = 1;
            end
`else
            p_pc = EVEC;
`endif
        end
    endtask

    // Inputs are set shortly after a rising edge; this checks the
    // combinational outputs at the falling edge and the registered ones
    // just after the next rising edge.
    task automatic tick();
        predict();
        @(negedge clk);
        check("pc_inc", 32'(pc_inc), 32'((m_pc + INC) % MOD));
        check("next_pc", 32'(next_pc), 32'(p_pc));
        @(posedge clk);
        m_pc = p_pc; m_epc = p_epc; m_halted = p_halted; m_exc = p_exc; m_mis = p_mis;
        #1;
        check("pc", 32'(pc), 32'(m_pc));
        check("halted", 32'(halted), 32'(m_halted));
        check("misalign", 32'(misalign), 32'(m_mis));
        check("epc", 32'(epc), 32'(m_epc));
    endtask

    task automatic idle();
        stall = 0; br_taken = 0; jr = 0; siic = 0; rti = 0; halt = 0;
        redir_pc = '0; imm = '0; rs = '0;
    endtask

    // Asserts reset mid-cycle and verifies the asynchronous effect before
    // the next edge, then releases it after that edge.
    task automatic do_reset();
        rst = 1;
        #1;
        check("rst_pc", 32'(pc), 32'(RVEC));
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_epc", 32'(epc), 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    initial begin
        idle();
        @(posedge clk); #1;

        // 1: reset and free run
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t1_seq", 32'(pc), 32'(2 * i));
        end

        // 2: taken branch overrides stall
        br_taken = 1; stall = 1; redir_pc = 16'h0010; imm = 16'h0008;
        tick();
        check("t2_br", 32'(pc), 32'h001A);
        idle();

        // 3: aligned jump, then misaligned jump traps
        jr = 1; rs = 16'h0100; imm = 16'hFFFE;
        tick();
        check("t3_jr", 32'(pc), 32'h00FE);
        rs = 16'h0101; imm = 16'h0000;
        tick();
        check("t3_mis_pc", 32'(pc), 32'h0002);
        check("t3_mis_hi", 32'(misalign), 32'd1);
        idle();
        tick();
        check("t3_mis_lo", 32'(misalign), 32'd0);

`ifdef PC_EPC_EN
        // 4: trap, return, double fault
        do_reset();
        siic = 1; redir_pc = 16'h0040;
        tick();
        check("t4_trap_pc", 32'(pc), 32'h0002);
        check("t4_epc", 32'(epc), 32'h0042);
        idle(); rti = 1;
        tick();
        check("t4_rti_pc", 32'(pc), 32'h0042);
        idle(); siic = 1; redir_pc = 16'h0050;
        tick();
        tick();
        check("t4_dbl_halt", 32'(halted), 32'd1);
        check("t4_dbl_pc", 32'(pc), 32'h0002);
        idle();
`endif

        // 5: halt freezes the PC until reset
        do_reset();
        tick();
        halt = 1;
        tick();
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_pc", 32'(pc), 32'h0002);
        idle(); br_taken = 1; jr = 1; rs = 16'h0200; redir_pc = 16'h0300; imm = 16'h0010;
        tick();
        tick();
        check("t5_frozen", 32'(pc), 32'h0002);
        idle();
        do_reset();

        // 6: wrap and stall
        jr = 1; rs = 16'hFFFE;
        tick();
        check("t6_top", 32'(pc), 32'hFFFE);
        idle();
        tick();
        check("t6_wrap", 32'(pc), 32'h0000);
        stall = 1;
        tick();
        check("t6_stall", 32'(pc), 32'h0000);
        idle();

        // Randomized stimulus against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (m_halted && $urandom_range(3) == 0) begin
                idle();
                do_reset();
            end
            siic     = ($urandom_range(31) == 0);
            rti      = ($urandom_range(11) == 0);
            halt     = ($urandom_range(79) == 0);
            jr       = ($urandom_range(9) == 0);
            br_taken = ($urandom_range(5) == 0);
            stall    = ($urandom_range(3) == 0);
            redir_pc = W'($urandom);
            rs       = W'($urandom);
            imm      = W'($urandom);
            if ($urandom_range(3) != 0) begin
                redir_pc[0] = 1'b0; rs[0] = 1'b0; imm[0] = 1'b0;
            end
            tick();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
